// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types for the data-memory bus bridge: SRAM-like bus request/response
// bundles, access size encoding and the bridge handshake states.
package dmem_sram_bridge_pkg;

    localparam int DBUS_ADDR_W = 32;
    localparam int DBUS_DATA_W = 32;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_REQ  = 2'd1,
        DM_WAIT = 2'd2,
        DM_DONE = 2'd3
    } dmem_state_t;

    typedef struct packed {
        logic                   req;
        logic                   wr;
        logic [1:0]             size;
        logic [DBUS_ADDR_W-1:0] addr;
        logic [DBUS_DATA_W-1:0] wdata;
    } dbus_req_t;

    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [DBUS_DATA_W-1:0] rdata;
    } dbus_resp_t;

endpackage

// File: rtl/dmem_sram_bridge.sv
// Turns the M stage's single-cycle load/store into one SRAM-like bus transaction
// (address phase, then data phase) and stalls M until the data phase completes.
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_kill,
    input  logic              mem_advance,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    dmem_state_t       state_q, state_d;
    logic              drain_q, drain_d;
    logic              data_req_q, data_req_d;
    logic              data_wr_q, data_wr_d;
    logic [1:0]        data_size_q, data_size_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              req_valid_s;
    logic              done_s;
    logic              discard_s;
    logic              mem_stall_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // Next-state, latched request copy and the combinational stall/rdata view.
    always_comb begin
        req_valid_s  = (mem_ren | mem_wen) & ~mem_kill;
        state_d      = state_q;
        drain_d      = drain_q;
        data_req_d   = data_req_q;
        data_wr_d    = data_wr_q;
        data_size_d  = data_size_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        mem_rdata_d  = mem_rdata_q;
        mem_stall_s  = 1'b0;
        mem_rdata_s  = mem_rdata_q;
        // A data phase only counts in REQ when the address phase is accepted too.
        done_s       = (state_q == DM_REQ)  ? (data_addr_ok & data_data_ok) :
                       (state_q == DM_WAIT) ? data_data_ok : 1'b0;
        discard_s    = drain_q | mem_kill;

        case (state_q)
            DM_IDLE: begin
                mem_stall_s = req_valid_s;
                if (req_valid_s) begin
                    state_d      = DM_REQ;
                    data_req_d   = 1'b1;
                    data_wr_d    = mem_wen;
                    data_size_d  = mem_size;
                    data_addr_d  = mem_addr;
                    data_wdata_d = mem_wdata;
                end else begin
                    state_d = DM_IDLE;
                end
            end
            DM_REQ, DM_WAIT: begin
                if (drain_q) begin
                    mem_stall_s = req_valid_s;
                end else begin
                    mem_stall_s = ~done_s;
                    if (done_s) begin
                        mem_rdata_s = data_rdata;
                    end else begin
                        mem_rdata_s = mem_rdata_q;
                    end
                end
                if ((state_q == DM_REQ) && data_addr_ok) begin
                    data_req_d = 1'b0;
                end else begin
                    data_req_d = data_req_q;
                end
                if (done_s) begin
                    drain_d = 1'b0;
                    state_d = discard_s ? DM_IDLE : DM_DONE;
                    if (!discard_s && !data_wr_q) begin
                        mem_rdata_d = data_rdata;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                end else begin
                    drain_d = drain_q | mem_kill;
                    if ((state_q == DM_REQ) && data_addr_ok) begin
                        state_d = DM_WAIT;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            DM_DONE: begin
                if (mem_kill || mem_advance) begin
                    state_d = DM_IDLE;
                end else begin
                    state_d = DM_DONE;
                end
            end
            default: begin
                state_d    = DM_IDLE;
                drain_d    = 1'b0;
                data_req_d = 1'b0;
            end
        endcase
    end

    // Bridge state and registered bus request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DM_IDLE;
            drain_q      <= 1'b0;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'd0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            data_req_q   <= data_req_d;
            data_wr_q    <= data_wr_d;
            data_size_q  <= data_size_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign mem_rdata  = mem_rdata_s;
    assign mem_stall  = mem_stall_s;
    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: each scenario drives the M-stage and bus
// inputs cycle by cycle and compares against hand-computed values.
module tb_dmem_sram_bridge;

    logic        clk;
    logic        reset;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_kill;
    logic        mem_advance;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_checks;
    int n_errors;

    dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_kill     (mem_kill),
        .mem_advance  (mem_advance),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock, then settle inputs just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_size     = 2'd2;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_kill     = 1'b0;
        mem_advance  = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        step();
        step();
        reset = 1'b0;
        settle();
        check_val("rst_req",   {31'd0, data_req},  32'd0);
        check_val("rst_stall", {31'd0, mem_stall}, 32'd0);
        check_val("rst_rdata", mem_rdata,          32'd0);
        check_val("rst_addr",  data_addr,          32'd0);

        // Zero-wait read
        mem_ren = 1'b1; mem_size = 2'd2; mem_addr = 32'h8000_0100;
        settle();
        check_val("zw_idle_stall", {31'd0, mem_stall}, 32'd1);
        check_val("zw_idle_req",   {31'd0, data_req},  32'd0);
        step();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        settle();
        check_val("zw_req",       {31'd0, data_req},  32'd1);
        check_val("zw_addr",      data_addr,          32'h8000_0100);
        check_val("zw_wr",        {31'd0, data_wr},   32'd0);
        check_val("zw_stall",     {31'd0, mem_stall}, 32'd0);
        check_val("zw_rdata_now", mem_rdata,          32'hDEAD_BEEF);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        check_val("zw_done_req",   {31'd0, data_req},  32'd0);
        check_val("zw_done_stall", {31'd0, mem_stall}, 32'd0);
        check_val("zw_done_rdata", mem_rdata,          32'hDEAD_BEEF);
        step();
        settle();
        check_val("zw_hold_req", {31'd0, data_req}, 32'd0);
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0; mem_ren = 1'b0;
        settle();
        check_val("zw_idle_after", {31'd0, mem_stall}, 32'd0);

        // Delayed-handshake byte store
        mem_wen = 1'b1; mem_size = 2'd0; mem_addr = 32'h8000_0003; mem_wdata = 32'h0000_5A00;
        settle();
        check_val("wr_idle_stall", {31'd0, mem_stall}, 32'd1);
        step();
        mem_addr = 32'h1234_0000; mem_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            settle();
            check_val("wr_req",   {31'd0, data_req},  32'd1);
            check_val("wr_wr",    {31'd0, data_wr},   32'd1);
            check_val("wr_size",  {30'd0, data_size}, 32'd0);
            check_val("wr_addr",  data_addr,          32'h8000_0003);
            check_val("wr_wdata", data_wdata,         32'h0000_5A00);
            check_val("wr_stall", {31'd0, mem_stall}, 32'd1);
            step();
        end
        data_addr_ok = 1'b0;
        settle();
        check_val("wr_wait_req",   {31'd0, data_req},  32'd0);
        check_val("wr_wait_stall", {31'd0, mem_stall}, 32'd1);
        step();
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        settle();
        check_val("wr_ok_stall", {31'd0, mem_stall}, 32'd0);
        step();
        data_data_ok = 1'b0;
        settle();
        check_val("wr_done_rdata", mem_rdata,          32'hDEAD_BEEF);
        check_val("wr_done_stall", {31'd0, mem_stall}, 32'd0);
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0; mem_wen = 1'b0; mem_size = 2'd2;

        // Kill mid-flight
        mem_ren = 1'b1; mem_addr = 32'h8000_0180;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; mem_kill = 1'b1;
        settle();
        check_val("kl_wait_stall", {31'd0, mem_stall}, 32'd1);
        step();
        mem_kill = 1'b0; mem_addr = 32'h8000_0200;
        settle();
        check_val("kl_drain_stall", {31'd0, mem_stall}, 32'd1);
        check_val("kl_drain_req",   {31'd0, data_req},  32'd0);
        step();
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        settle();
        check_val("kl_ok_stall", {31'd0, mem_stall}, 32'd1);
        check_val("kl_ok_rdata", mem_rdata,          32'hDEAD_BEEF);
        step();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        check_val("kl_idle_stall", {31'd0, mem_stall}, 32'd1);
        check_val("kl_idle_req",   {31'd0, data_req},  32'd0);
        check_val("kl_idle_rdata", mem_rdata,          32'hDEAD_BEEF);
        step();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
        settle();
        check_val("kl_new_req",   {31'd0, data_req}, 32'd1);
        check_val("kl_new_addr",  data_addr,         32'h8000_0200);
        check_val("kl_new_rdata", mem_rdata,         32'h2222_2222);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; mem_advance = 1'b1;
        settle();
        check_val("kl_done_rdata", mem_rdata, 32'h2222_2222);
        step();
        mem_advance = 1'b0; mem_ren = 1'b0;

        // Kill in IDLE
        mem_ren = 1'b1; mem_kill = 1'b1; mem_addr = 32'h8000_0280;
        settle();
        check_val("ki_stall", {31'd0, mem_stall}, 32'd0);
        step();
        settle();
        check_val("ki_req", {31'd0, data_req}, 32'd0);
        mem_ren = 1'b0; mem_kill = 1'b0;
        step();

        // Back-to-back loads
        mem_ren = 1'b1; mem_addr = 32'h8000_0000;
        step();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hAAAA_0000;
        settle();
        check_val("bb1_req",  {31'd0, data_req}, 32'd1);
        check_val("bb1_addr", data_addr,         32'h8000_0000);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0; mem_addr = 32'h8000_0004;
        settle();
        check_val("bb_gap_req",   {31'd0, data_req},  32'd0);
        check_val("bb_gap_stall", {31'd0, mem_stall}, 32'd1);
        check_val("bb_gap_rdata", mem_rdata,          32'hAAAA_0000);
        step();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hBBBB_0004;
        settle();
        check_val("bb2_req",  {31'd0, data_req}, 32'd1);
        check_val("bb2_addr", data_addr,         32'h8000_0004);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        check_val("bb2_req_once", {31'd0, data_req}, 32'd0);
        check_val("bb2_rdata",    mem_rdata,         32'hBBBB_0004);
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0; mem_ren = 1'b0;

        // Reset during WAIT
        mem_wen = 1'b1; mem_size = 2'd2; mem_addr = 32'h8000_0300; mem_wdata = 32'hCAFE_F00D;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; reset = 1'b1;
        settle();
        check_val("rw_pre_wr", {31'd0, data_wr}, 32'd1);
        step();
        reset = 1'b0; mem_wen = 1'b0;
        settle();
        check_val("rw_req",   {31'd0, data_req},  32'd0);
        check_val("rw_wr",    {31'd0, data_wr},   32'd0);
        check_val("rw_size",  {30'd0, data_size}, 32'd0);
        check_val("rw_addr",  data_addr,          32'd0);
        check_val("rw_wdata", data_wdata,         32'd0);
        check_val("rw_rdata", mem_rdata,          32'd0);
        check_val("rw_stall", {31'd0, mem_stall}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h3333_3333;
        settle();
        check_val("rw_stray_stall", {31'd0, mem_stall}, 32'd0);
        check_val("rw_stray_rdata", mem_rdata,          32'd0);
        step();
        data_data_ok = 1'b0;
        settle();
        check_val("rw_after_rdata", mem_rdata,         32'd0);
        check_val("rw_after_req",   {31'd0, data_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
